// File: rtl/hamming_secded_codec_pkg.sv
// Shared constants and elaboration-time helpers for the Hamming SECDED codec.
package hamming_secded_codec_pkg;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    function automatic logic is_pow2(input int unsigned x);
        return (x != 0) && ((x & (x - 1)) == 0);
    endfunction

    // Smallest p with 2**p >= data_w + p + 1.
    function automatic int unsigned parity_bits(input int unsigned data_w);
        int unsigned p;
        p = 1;
        while ((32'd1 << p) < (data_w + p + 1)) p++;
        return p;
    endfunction

    // Codeword position of data bit k: the k-th non-power-of-two position from 3 up.
    function automatic int unsigned data_pos(input int unsigned k);
        int unsigned pos;
        int unsigned n;
        pos = 2;
        n   = 0;
        while (n <= k) begin
            pos++;
            if (!is_pow2(pos)) n++;
        end
        return pos;
    endfunction

endpackage

// File: rtl/hamming_secded_codec_if.sv
// Input/output streaming bus of the SECDED codec.
interface hamming_secded_codec_if
    import hamming_secded_codec_pkg::*;
#(
    parameter int unsigned DATA_W = 16
);
    localparam int unsigned P      = parity_bits(DATA_W);
    localparam int unsigned CODE_W = DATA_W + P + 1;

    logic              in_valid;
    logic              in_ready;
    logic              in_mode;
    logic [CODE_W-1:0] in_word;
    logic              out_valid;
    logic              out_ready;
    logic              out_mode;
    logic [CODE_W-1:0] out_code;
    logic [DATA_W-1:0] out_data;
    logic [P-1:0]      out_syndrome;
    logic              out_corr;
    logic              out_uncorr;

    modport master (
        output in_valid, in_mode, in_word, out_ready,
        input  in_ready, out_valid, out_mode, out_code, out_data,
               out_syndrome, out_corr, out_uncorr
    );

    modport slave (
        input  in_valid, in_mode, in_word, out_ready,
        output in_ready, out_valid, out_mode, out_code, out_data,
               out_syndrome, out_corr, out_uncorr
    );
endinterface

// File: rtl/hamming_secded_codec_syndrome.sv
// Hamming syndrome (XOR of indices of set bits 1..CODE_W-1) and overall parity of a codeword.
module hamming_secded_codec_syndrome #(
    parameter int unsigned CODE_W = 22,
    parameter int unsigned P      = 5
) (
    input  logic [CODE_W-1:0] code,
    output logic [P-1:0]      syndrome,
    output logic              overall
);
    always_comb begin
        syndrome = '0;
        for (int unsigned i = 1; i < CODE_W; i++) begin
            if (code[i]) syndrome = syndrome ^ P'(i);
        end
        overall = ^code;
    end
endmodule

// File: rtl/hamming_secded_codec.sv
// Two-stage pipelined Hamming SECDED encoder/decoder with valid/ready on both
// sides and saturating corrected/uncorrectable counters.
module hamming_secded_codec
    import hamming_secded_codec_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    hamming_secded_codec_if.slave    bus,
    input  logic                     cnt_clr,
    output logic [CNT_W-1:0]         corr_cnt,
    output logic [CNT_W-1:0]         uncorr_cnt
);
    localparam int unsigned P      = parity_bits(DATA_W);
    localparam int unsigned CODE_W = DATA_W + P + 1;

    // Stage 1 state
    logic              s1_valid;
    logic              s1_mode;
    logic [CODE_W-1:0] s1_word;
    logic [P-1:0]      s1_syn;
    logic              s1_ovr;

    // Stage 2 (output) state
    logic              out_valid_q;
    logic              out_mode_q;
    logic [CODE_W-1:0] out_code_q;
    logic [DATA_W-1:0] out_data_q;
    logic [P-1:0]      out_syn_q;
    logic              out_corr_q;
    logic              out_uncorr_q;

    logic              s2_load_c;
    logic              in_fire_c;
    logic              out_fire_c;
    logic [CODE_W-1:0] enc_word_c;
    logic [CODE_W-1:0] s1_in_c;
    logic [P-1:0]      syn_c;
    logic              ovr_c;
    logic [CODE_W-1:0] s2_code_c;
    logic [DATA_W-1:0] s2_data_c;
    logic [P-1:0]      s2_syn_c;
    logic              s2_corr_c;
    logic              s2_uncorr_c;

    // Data scatter into codeword positions; parity positions and bit 0 start at zero.
    for (genvar k = 0; k < DATA_W; k++) begin : g_scatter
        localparam int unsigned POS = data_pos(k);
        assign enc_word_c[POS] = bus.in_word[k];
    end
    for (genvar j = 0; j < P; j++) begin : g_par_zero
        assign enc_word_c[2**j] = 1'b0;
    end
    assign enc_word_c[0] = 1'b0;

    // Same syndrome logic serves both modes: for encode it yields the parity bits.
    assign s1_in_c = (bus.in_mode == MODE_DEC) ? bus.in_word : enc_word_c;

    hamming_secded_codec_syndrome #(
        .CODE_W (CODE_W),
        .P      (P)
    ) u_syndrome (
        .code     (s1_in_c),
        .syndrome (syn_c),
        .overall  (ovr_c)
    );

    assign s2_load_c    = s1_valid && (!out_valid_q || bus.out_ready);
    assign bus.in_ready = !rst && (!s1_valid || s2_load_c);
    assign in_fire_c    = bus.in_valid && bus.in_ready;
    assign out_fire_c   = out_valid_q && bus.out_ready;

    // Stage 2 combinational: insert parity (encode) or classify and correct (decode).
    always_comb begin
        s2_code_c   = s1_word;
        s2_syn_c    = '0;
        s2_corr_c   = 1'b0;
        s2_uncorr_c = 1'b0;
        if (s1_mode == MODE_ENC) begin
            for (int j = 0; j < int'(P); j++) s2_code_c[2**j] = s1_syn[j];
            s2_code_c[0] = s1_ovr ^ (^s1_syn);
        end else begin
            s2_syn_c = s1_syn;
            if (s1_ovr) begin
                if (32'(s1_syn) < CODE_W) begin
                    s2_code_c = s1_word ^ (CODE_W'(1) << s1_syn);
                    s2_corr_c = 1'b1;
                end else begin
                    s2_uncorr_c = 1'b1;
                end
            end else if (s1_syn != '0) begin
                s2_uncorr_c = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < DATA_W; k++) begin : g_gather
        localparam int unsigned POS = data_pos(k);
        assign s2_data_c[k] = s2_code_c[POS];
    end

    // Pipeline registers
    always_ff @(posedge clk) begin : p_pipe
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_mode      <= 1'b0;
            s1_word      <= '0;
            s1_syn       <= '0;
            s1_ovr       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_mode_q   <= 1'b0;
            out_code_q   <= '0;
            out_data_q   <= '0;
            out_syn_q    <= '0;
            out_corr_q   <= 1'b0;
            out_uncorr_q <= 1'b0;
        end else begin
            if (bus.in_ready) s1_valid <= bus.in_valid;
            if (in_fire_c) begin
                s1_mode <= bus.in_mode;
                s1_word <= s1_in_c;
                s1_syn  <= syn_c;
                s1_ovr  <= ovr_c;
            end
            if (s2_load_c) begin
                out_valid_q  <= 1'b1;
                out_mode_q   <= s1_mode;
                out_code_q   <= s2_code_c;
                out_data_q   <= s2_data_c;
                out_syn_q    <= s2_syn_c;
                out_corr_q   <= s2_corr_c;
                out_uncorr_q <= s2_uncorr_c;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Saturating status counters; clear has priority over increment.
    always_ff @(posedge clk) begin : p_counters
        if (rst || cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            if (out_fire_c && out_corr_q && !(&corr_cnt))
                corr_cnt <= corr_cnt + CNT_W'(1);
            if (out_fire_c && out_uncorr_q && !(&uncorr_cnt))
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.out_mode     = out_mode_q;
    assign bus.out_code     = out_code_q;
    assign bus.out_data     = out_data_q;
    assign bus.out_syndrome = out_syn_q;
    assign bus.out_corr     = out_corr_q;
    assign bus.out_uncorr   = out_uncorr_q;

endmodule

// File: tb/tb_hamming_secded_codec.sv
// Self-checking bench for hamming_secded_codec (DATA_W=16, CNT_W=2) against a
// position-based reference encoder and an error-injection-aware decode model.
module tb_hamming_secded_codec;

    localparam int unsigned DW  = 16;
    localparam int unsigned CW  = 22;
    localparam int unsigned PW  = 5;
    localparam int unsigned CNW = 2;

    typedef struct packed {
        logic          mode;
        logic [CW-1:0] code;
        logic [DW-1:0] data;
        logic [PW-1:0] syn;
        logic          corr;
        logic          uncorr;
    } res_t;

    typedef struct packed {
        logic          mode;
        logic [CW-1:0] word;
        res_t          exp;
    } txn_t;

    logic           clk;
    logic           rst;
    logic           cnt_clr;
    logic [CNW-1:0] corr_cnt;
    logic [CNW-1:0] uncorr_cnt;
    int             tests;
    int             fails;

    hamming_secded_codec_if #(.DATA_W(DW)) bus ();

    hamming_secded_codec #(
        .DATA_W (DW),
        .CNT_W  (CNW)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cnt_clr    (cnt_clr),
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder built straight from the position rules.
    function automatic logic [CW-1:0] ref_encode(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        int k;
        c = '0;
        k = 0;
        for (int pos = 1; pos < int'(CW); pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[k];
                k++;
            end
        end
        for (int j = 0; j < int'(PW); j++)
            for (int pos = 1; pos < int'(CW); pos++)
                if (((pos >> j) & 1) == 1 && pos != (1 << j)) c[1 << j] = c[1 << j] ^ c[pos];
        c[0] = ^c[CW-1:1];
        return c;
    endfunction

    function automatic logic [DW-1:0] ref_gather(input logic [CW-1:0] c);
        logic [DW-1:0] d;
        int k;
        d = '0;
        k = 0;
        for (int pos = 1; pos < int'(CW); pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[k] = c[pos];
                k++;
            end
        end
        return d;
    endfunction

    // Expected result knowing which bits were flipped on the clean codeword.
    function automatic res_t ref_result(input logic mode, input logic [DW-1:0] d,
                                        input int nerr, input int a, input int b);
        res_t r;
        logic [CW-1:0] raw;
        r.mode   = mode;
        r.code   = ref_encode(d);
        r.data   = d;
        r.syn    = '0;
        r.corr   = 1'b0;
        r.uncorr = 1'b0;
        if (mode && nerr == 1) begin
            r.syn  = PW'(a);
            r.corr = 1'b1;
        end else if (mode && nerr == 2) begin
            raw      = r.code;
            raw[a]   = ~raw[a];
            raw[b]   = ~raw[b];
            r.code   = raw;
            r.data   = ref_gather(raw);
            r.syn    = PW'(a ^ b);
            r.uncorr = 1'b1;
        end
        return r;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        logic [DW-1:0] d;
        int nerr, a, b;
        t.mode = 1'($urandom_range(0, 1));
        d      = DW'($urandom);
        nerr   = t.mode ? int'($urandom_range(0, 2)) : 0;
        a      = int'($urandom_range(0, CW - 1));
        b      = (a + int'($urandom_range(1, CW - 1))) % int'(CW);
        if (t.mode) begin
            t.word = ref_encode(d);
            if (nerr >= 1) t.word[a] = ~t.word[a];
            if (nerr == 2) t.word[b] = ~t.word[b];
        end else begin
            t.word = {6'($urandom), d};
        end
        t.exp = ref_result(t.mode, d, nerr, a, b);
        return t;
    endfunction

    function automatic res_t observe();
        return {bus.out_mode, bus.out_code, bus.out_data, bus.out_syndrome,
                bus.out_corr, bus.out_uncorr};
    endfunction

    // One clock: drive inputs after the edge, then sample handshake and output payload.
    task automatic tick(input logic iv, input logic md, input logic [CW-1:0] w, input logic ordy,
                        output logic acc_in, output logic ov, output res_t obs);
        @(posedge clk);
        #1;
        bus.in_valid  = iv;
        bus.in_mode   = md;
        bus.in_word   = w;
        bus.out_ready = ordy;
        #1;
        acc_in = iv && bus.in_ready;
        ov     = bus.out_valid;
        obs    = observe();
    endtask

    // Send one word on an idle pipe; lat counts edges from accept to out_valid.
    task automatic send_one(input logic md, input logic [CW-1:0] w, output res_t got, output int lat);
        logic acc, ov;
        res_t obs;
        int   guard;
        guard = 0;
        do begin
            tick(1'b1, md, w, 1'b1, acc, ov, obs);
            guard++;
        end while (!acc && guard < 20);
        lat = 0;
        do begin
            tick(1'b0, 1'b0, '0, 1'b1, acc, ov, obs);
            lat++;
        end while (!ov && lat < 20);
        got = obs;
    endtask

    task automatic test_reset();
        rst = 1'b1; cnt_clr = 1'b0;
        bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_word = '0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b exp 0", bus.in_ready); end
        tests++;
        if (bus.out_valid !== 1'b0 || observe() !== '0) begin
            fails++; $display("FAIL reset_out: valid %b payload %h exp 0/0", bus.out_valid, observe());
        end
        tests++;
        if (corr_cnt !== '0 || uncorr_cnt !== '0) begin
            fails++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0", corr_cnt, uncorr_cnt);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_directed();
        res_t got, exp;
        int lat;
        logic acc, ov;
        res_t obs;
        logic [CW-1:0] words [5];
        logic          modes [5];
        words[0] = 22'h000000; modes[0] = 1'b0;
        words[1] = 22'h000001; modes[1] = 1'b0;
        words[2] = 22'h00000F; modes[2] = 1'b1;
        words[3] = 22'h00004F; modes[3] = 1'b1;
        words[4] = 22'h00024F; modes[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            case (i)
                0:       exp = {1'b0, 22'h000000, 16'h0000, 5'd0,  1'b0, 1'b0};
                1:       exp = {1'b0, 22'h00000F, 16'h0001, 5'd0,  1'b0, 1'b0};
                2:       exp = {1'b1, 22'h00000F, 16'h0001, 5'd0,  1'b0, 1'b0};
                3:       exp = {1'b1, 22'h00000F, 16'h0001, 5'd6,  1'b1, 1'b0};
                default: exp = {1'b1, 22'h00024F, 16'h0015, 5'd15, 1'b0, 1'b1};
            endcase
            send_one(modes[i], words[i], got, lat);
            tests++;
            if (lat !== 2) begin fails++; $display("FAIL latency_%0d: got %0d exp 2", i, lat); end
            tests++;
            if (got !== exp) begin fails++; $display("FAIL directed_%0d: got %h exp %h", i, got, exp); end
        end
        tick(1'b0, 1'b0, '0, 1'b1, acc, ov, obs);
        tests++;
        if (corr_cnt !== 2'd1 || uncorr_cnt !== 2'd1) begin
            fails++; $display("FAIL directed_cnt: got %0d/%0d exp 1/1", corr_cnt, uncorr_cnt);
        end
    endtask

    task automatic test_counters();
        res_t got;
        int lat;
        logic acc, ov;
        res_t obs;
        cnt_clr = 1'b1;
        tick(1'b0, 1'b0, '0, 1'b1, acc, ov, obs);
        cnt_clr = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_one(1'b1, 22'h00004F, got, lat);
            tick(1'b0, 1'b0, '0, 1'b1, acc, ov, obs);
            tests++;
            if (corr_cnt !== CNW'((i > 3) ? 3 : i)) begin
                fails++; $display("FAIL corr_cnt_sat_%0d: got %0d exp %0d", i, corr_cnt, (i > 3) ? 3 : i);
            end
        end
        // Clear lands on the same edge as an increment.
        send_one(1'b1, 22'h00004F, got, lat);
        cnt_clr = 1'b1;
        tick(1'b0, 1'b0, '0, 1'b1, acc, ov, obs);
        cnt_clr = 1'b0;
        tests++;
        if (corr_cnt !== '0) begin fails++; $display("FAIL clr_wins: got %0d exp 0", corr_cnt); end
    endtask

    task automatic test_backpressure();
        txn_t  txq [$];
        res_t  expq [$];
        res_t  obs, prev, e;
        logic  acc, ov, stall;
        int    sent, got, c;
        for (int i = 0; i < 4; i++) txq.push_back(rand_txn());
        sent = 0; got = 0; c = 0; stall = 1'b0; prev = '0;
        while (got < 4 && c < 50) begin
            tick(sent < 4, txq[sent % 4].mode, txq[sent % 4].word, c >= 3, acc, ov, obs);
            if (c == 2) begin
                tests++;
                if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b exp 0", bus.in_ready); end
            end
            if (stall) begin
                tests++;
                if (obs !== prev) begin fails++; $display("FAIL bp_stable: got %h exp %h", obs, prev); end
            end
            if (acc) begin expq.push_back(txq[sent].exp); sent++; end
            if (ov && c >= 3) begin
                e = (expq.size() > 0) ? expq.pop_front() : '0;
                tests++;
                if (obs !== e) begin fails++; $display("FAIL bp_order_%0d: got %h exp %h", got, obs, e); end
                got++;
            end
            stall = ov && (c < 3);
            prev  = obs;
            c++;
        end
        tests++;
        if (got != 4) begin fails++; $display("FAIL bp_timeout: got %0d words exp 4", got); end
    endtask

    task automatic test_back_to_back();
        res_t expq [$];
        res_t obs, e;
        txn_t t;
        logic acc, ov;
        int   got, c;
        got = 0;
        t = rand_txn();
        for (c = 0; c < 24; c++) begin
            tick(c < 20, t.mode, t.word, 1'b1, acc, ov, obs);
            if (c < 20) begin
                tests++;
                if (acc !== 1'b1) begin fails++; $display("FAIL b2b_accept_%0d: got %b exp 1", c, acc); end
            end
            if (acc) begin expq.push_back(t.exp); t = rand_txn(); end
            if (c >= 2 && c < 22) begin
                e = (expq.size() > 0) ? expq.pop_front() : '0;
                tests++;
                if (ov !== 1'b1 || obs !== e) begin
                    fails++; $display("FAIL b2b_out_%0d: valid %b got %h exp %h", c, ov, obs, e);
                end
                got++;
            end
        end
    endtask

    task automatic test_random_stream();
        localparam int N = 200;
        res_t expq [$];
        res_t obs, prev, e;
        txn_t t;
        logic acc, ov, ordy, stall;
        int   sent, got, cyc, n_corr, n_unc;
        cnt_clr = 1'b1;
        tick(1'b0, 1'b0, '0, 1'b0, acc, ov, obs);
        cnt_clr = 1'b0;
        sent = 0; got = 0; cyc = 0; n_corr = 0; n_unc = 0; stall = 1'b0; prev = '0;
        t = rand_txn();
        while (got < N && cyc < 5000) begin
            ordy = ($urandom_range(0, 3) != 0);
            tick((sent < N) && ($urandom_range(0, 3) != 0), t.mode, t.word, ordy, acc, ov, obs);
            if (stall) begin
                tests++;
                if (obs !== prev) begin fails++; $display("FAIL rnd_stable_%0d: got %h exp %h", cyc, obs, prev); end
            end
            if (acc) begin expq.push_back(t.exp); sent++; t = rand_txn(); end
            if (ov && ordy) begin
                e = (expq.size() > 0) ? expq.pop_front() : '0;
                tests++;
                if (obs !== e) begin fails++; $display("FAIL rnd_word_%0d: got %h exp %h", got, obs, e); end
                if (e.corr && n_corr < 3) n_corr++;
                if (e.uncorr && n_unc < 3) n_unc++;
                got++;
            end
            stall = ov && !ordy;
            prev  = obs;
            cyc++;
        end
        tests++;
        if (got != N) begin fails++; $display("FAIL rnd_timeout: got %0d words exp %0d", got, N); end
        tick(1'b0, 1'b0, '0, 1'b1, acc, ov, obs);
        tests++;
        if (corr_cnt !== CNW'(n_corr) || uncorr_cnt !== CNW'(n_unc)) begin
            fails++; $display("FAIL rnd_cnt: got %0d/%0d exp %0d/%0d", corr_cnt, uncorr_cnt, n_corr, n_unc);
        end
    endtask

    task automatic test_reset_mid();
        logic acc, ov;
        res_t obs, got, exp;
        int   lat;
        tick(1'b1, 1'b0, 22'h00ABCD, 1'b0, acc, ov, obs);
        tick(1'b1, 1'b1, 22'h00004F, 1'b0, acc, ov, obs);
        tick(1'b1, 1'b0, 22'h001234, 1'b0, acc, ov, obs);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        tests++;
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rst_cycle_in_ready: got %b exp 0", bus.in_ready); end
        @(posedge clk);
        #1;
        tests++;
        if (bus.out_valid !== 1'b0 || observe() !== '0) begin
            fails++; $display("FAIL rst_mid_out: valid %b payload %h exp 0/0", bus.out_valid, observe());
        end
        rst = 1'b0;
        send_one(1'b0, 22'h005A5A, got, lat);
        exp = ref_result(1'b0, 16'h5A5A, 0, 0, 0);
        tests++;
        if (got !== exp || lat !== 2) begin
            fails++; $display("FAIL rst_mid_after: got %h lat %0d exp %h lat 2", got, lat, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_counters();
        test_backpressure();
        test_back_to_back();
        test_random_stream();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
